// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT blocks: state enum, bit reversal, twiddle indexing.
package fft_pkg;

    localparam int DEFAULT_TWIDDLE_SCALE = 1000;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } fft_state_e;

    function automatic int unsigned bitrev(input int unsigned val, input int unsigned width);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < width; i++) begin
            r = (r << 1) | ((val >> i) & 32'd1);
        end
        return r;
    endfunction

    // Twiddle stride shrinks by half each stage: W_N^(j * N / 2^(s+1)).
    function automatic int unsigned twiddle_index(input int unsigned j, input int unsigned s,
                                                  input int unsigned log2n);
        return j << (log2n - 1 - s);
    endfunction

endpackage

// File: rtl/fft_iterative_engine_if.sv
// Sample-in / bin-out stream bundle for the iterative FFT engine.
interface fft_iterative_engine_if #(
    parameter int SAMPLE_W = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] in_real;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [SAMPLE_W-1:0] out_real;
    logic signed [SAMPLE_W-1:0] out_imag;
    logic                       out_last;

    modport master (
        output in_valid, in_real, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_last
    );

    modport slave (
        input  in_valid, in_real, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_last
    );
endinterface

// File: rtl/fft_radix2_butterfly.sv
// Combinational radix-2 DIT butterfly with integer twiddles scaled by TWIDDLE_SCALE.
// Macro FFT_STAGE_SCALE_EN: halve (floor) both outputs so a full transform is divided by N.
module fft_radix2_butterfly
    import fft_pkg::*;
#(
    parameter int SAMPLE_W      = 32,
    parameter int TWIDDLE_W     = 16,
    parameter int TWIDDLE_SCALE = DEFAULT_TWIDDLE_SCALE
) (
    input  logic signed [SAMPLE_W-1:0]  top_real,
    input  logic signed [SAMPLE_W-1:0]  top_imag,
    input  logic signed [SAMPLE_W-1:0]  bot_real,
    input  logic signed [SAMPLE_W-1:0]  bot_imag,
    input  logic signed [TWIDDLE_W-1:0] tw_real,
    input  logic signed [TWIDDLE_W-1:0] tw_imag,
    output logic signed [SAMPLE_W-1:0]  out_top_real,
    output logic signed [SAMPLE_W-1:0]  out_top_imag,
    output logic signed [SAMPLE_W-1:0]  out_bot_real,
    output logic signed [SAMPLE_W-1:0]  out_bot_imag
);
    localparam int PROD_W = SAMPLE_W + TWIDDLE_W + 1;
    // One extra bit so top +/- t never wraps before the optional halving.
    localparam int ACC_W = PROD_W + 1;
    localparam logic signed [ACC_W-1:0] SCALE = ACC_W'(TWIDDLE_SCALE);

    logic signed [ACC_W-1:0] ar, ai, br, bi, wr, wi;
    logic signed [ACC_W-1:0] t_re, t_im;
    logic signed [ACC_W-1:0] sum_re, sum_im, dif_re, dif_im;

    always_comb begin
        ar     = ACC_W'(top_real);
        ai     = ACC_W'(top_imag);
        br     = ACC_W'(bot_real);
        bi     = ACC_W'(bot_imag);
        wr     = ACC_W'(tw_real);
        wi     = ACC_W'(tw_imag);
        t_re   = (br * wr - bi * wi) / SCALE;
        t_im   = (br * wi + bi * wr) / SCALE;
        sum_re = ar + t_re;
        sum_im = ai + t_im;
        dif_re = ar - t_re;
        dif_im = ai - t_im;
`ifdef FFT_STAGE_SCALE_EN
        out_top_real = SAMPLE_W'(sum_re >>> 1);
        out_top_imag = SAMPLE_W'(sum_im >>> 1);
        out_bot_real = SAMPLE_W'(dif_re >>> 1);
        out_bot_imag = SAMPLE_W'(dif_im >>> 1);
`else
        out_top_real = SAMPLE_W'(sum_re);
        out_top_imag = SAMPLE_W'(sum_im);
        out_bot_real = SAMPLE_W'(dif_re);
        out_bot_imag = SAMPLE_W'(dif_im);
`endif
    end

endmodule

// File: rtl/fft_iterative_engine.sv
// In-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle, natural-order unload.
// Macro FFT_STAGE_SCALE_EN enables per-stage halving inside fft_radix2_butterfly.
module fft_iterative_engine
    import fft_pkg::*;
#(
    parameter int N_POINTS      = 32,
    parameter int SAMPLE_W      = 32,
    parameter int TWIDDLE_W     = 16,
    parameter int TWIDDLE_SCALE = DEFAULT_TWIDDLE_SCALE,
    localparam int ADDR_W       = $clog2(N_POINTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [TWIDDLE_W*N_POINTS/2-1:0] twiddles_real,
    input  logic [TWIDDLE_W*N_POINTS/2-1:0] twiddles_imag,
    fft_iterative_engine_if.slave           stream,
    output logic                            busy
);
    localparam int STAGE_W = $clog2(ADDR_W);
    localparam int BFLY_W  = ADDR_W - 1;

    fft_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [BFLY_W-1:0]   bfly_q, bfly_d;

    logic signed [SAMPLE_W-1:0] mem_re [N_POINTS];
    logic signed [SAMPLE_W-1:0] mem_im [N_POINTS];

    logic                        load_fire, out_fire;
    logic [ADDR_W-1:0]           load_addr, top_addr, bot_addr;
    logic [BFLY_W-1:0]           tw_idx;
    logic signed [TWIDDLE_W-1:0] tw_re, tw_im;
    logic signed [SAMPLE_W-1:0]  new_top_re, new_top_im, new_bot_re, new_bot_im;

    assign load_fire = (state_q == LOAD) && stream.in_valid;
    assign out_fire  = (state_q == UNLOAD) && stream.out_ready;
    assign load_addr = ADDR_W'(bitrev(32'(addr_q), ADDR_W));

    always_comb begin
        int unsigned s, b, half, j, top;
        s        = 32'(stage_q);
        b        = 32'(bfly_q);
        half     = 32'd1 << s;
        j        = b & (half - 32'd1);
        top      = ((b >> s) << (s + 32'd1)) + j;
        top_addr = ADDR_W'(top);
        bot_addr = ADDR_W'(top + half);
        tw_idx   = BFLY_W'(twiddle_index(j, s, ADDR_W));
    end

    assign tw_re = twiddles_real[32'(tw_idx)*TWIDDLE_W +: TWIDDLE_W];
    assign tw_im = twiddles_imag[32'(tw_idx)*TWIDDLE_W +: TWIDDLE_W];

    fft_radix2_butterfly #(
        .SAMPLE_W      (SAMPLE_W),
        .TWIDDLE_W     (TWIDDLE_W),
        .TWIDDLE_SCALE (TWIDDLE_SCALE)
    ) u_bfly (
        .top_real     (mem_re[top_addr]),
        .top_imag     (mem_im[top_addr]),
        .bot_real     (mem_re[bot_addr]),
        .bot_imag     (mem_im[bot_addr]),
        .tw_real      (tw_re),
        .tw_imag      (tw_im),
        .out_top_real (new_top_re),
        .out_top_imag (new_top_im),
        .out_bot_real (new_bot_re),
        .out_bot_imag (new_bot_im)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        unique case (state_q)
            LOAD: begin
                if (load_fire) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_q == '1) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                bfly_d = bfly_q + BFLY_W'(1);
                if (bfly_q == '1) begin
                    stage_d = stage_q + STAGE_W'(1);
                    if (stage_q == STAGE_W'(ADDR_W - 1)) begin
                        stage_d = '0;
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                if (out_fire) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_q == '1) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            addr_q  <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    // Sample memory needs no reset; every frame overwrites all entries during LOAD.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_re[load_addr] <= stream.in_real;
            mem_im[load_addr] <= '0;
        end else if (state_q == COMPUTE) begin
            mem_re[top_addr] <= new_top_re;
            mem_im[top_addr] <= new_top_im;
            mem_re[bot_addr] <= new_bot_re;
            mem_im[bot_addr] <= new_bot_im;
        end
    end

    assign stream.in_ready  = (state_q == LOAD);
    assign stream.out_valid = (state_q == UNLOAD);
    assign stream.out_last  = (state_q == UNLOAD) && (addr_q == '1);
    assign stream.out_real  = (state_q == UNLOAD) ? mem_re[addr_q] : '0;
    assign stream.out_imag  = (state_q == UNLOAD) ? mem_im[addr_q] : '0;
    assign busy             = (state_q == COMPUTE);

endmodule

// File: tb/tb_fft_iterative_engine.sv
// Self-checking bench for fft_iterative_engine: directed spectra plus random frames vs a DFT-recursion model.
module tb_fft_iterative_engine;
    localparam int N     = 32;
    localparam int SW    = 32;
    localparam int TW    = 16;
    localparam int SCALE = 1000;
    localparam int LOG2N = 5;
`ifdef FFT_STAGE_SCALE_EN
    localparam longint IMP_AMP = 1024, IMP_BIN = 32, DC_AMP = 64, DC_BIN0 = 64, ALT_BIN16 = 100;
`else
    localparam longint IMP_AMP = 1000, IMP_BIN = 1000, DC_AMP = 5, DC_BIN0 = 160, ALT_BIN16 = 3200;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [TW*N/2-1:0] tw_re_bus, tw_im_bus;
    int tests = 0;
    int fails = 0;

    longint wr [N/2];
    longint wi [N/2];
    longint xin [N];
    longint exp_re [N];
    longint exp_im [N];

    fft_iterative_engine_if #(.SAMPLE_W(SW)) bus ();

    fft_iterative_engine #(
        .N_POINTS      (N),
        .SAMPLE_W      (SW),
        .TWIDDLE_W     (TW),
        .TWIDDLE_SCALE (SCALE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .twiddles_real (tw_re_bus),
        .twiddles_imag (tw_im_bus),
        .stream        (bus),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint rnd(input real r);
        if (r >= 0.0) return longint'($rtoi(r + 0.5));
        return -longint'($rtoi(-r + 0.5));
    endfunction

    function automatic int tb_bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Butterfly result written back to a SW-bit word (optionally halved first).
    function automatic longint wrap(input longint v);
        logic signed [SW-1:0] w;
`ifdef FFT_STAGE_SCALE_EN
        v = v >>> 1;
`endif
        w = v[SW-1:0];
        return longint'(w);
    endfunction

    // Reference: combine sub-DFTs of size m/2 into size m: X[k] = E[k] +/- W_m^k O[k].
    function automatic void build_ref();
        longint er, ei, orr, oi, tr, ti;
        int widx;
        for (int n = 0; n < N; n++) begin
            exp_re[tb_bitrev(n)] = xin[n];
            exp_im[tb_bitrev(n)] = 0;
        end
        for (int m = 2; m <= N; m = m * 2) begin
            for (int base = 0; base < N; base += m) begin
                for (int k = 0; k < m / 2; k++) begin
                    widx = k * (N / m);
                    er  = exp_re[base + k];
                    ei  = exp_im[base + k];
                    orr = exp_re[base + k + m / 2];
                    oi  = exp_im[base + k + m / 2];
                    tr  = (orr * wr[widx] - oi * wi[widx]) / SCALE;
                    ti  = (orr * wi[widx] + oi * wr[widx]) / SCALE;
                    exp_re[base + k]         = wrap(er + tr);
                    exp_im[base + k]         = wrap(ei + ti);
                    exp_re[base + k + m / 2] = wrap(er - tr);
                    exp_im[base + k + m / 2] = wrap(ei - ti);
                end
            end
        end
    endfunction

    task automatic send_frame();
        int guard;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            guard = 0;
            while (!bus.in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            check("in_ready_load", longint'(bus.in_ready), 1);
            bus.in_valid = 1'b1;
            bus.in_real  = SW'(xin[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Drives junk on in_valid during COMPUTE; the engine must ignore it.
    task automatic wait_compute();
        int cycles = 0;
        check("in_ready_drops", longint'(bus.in_ready), 0);
        while (busy && cycles < 1000) begin
            bus.in_valid = 1'b1;
            bus.in_real  = $urandom();
            cycles++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("compute_cycles", cycles, (N / 2) * LOG2N);
    endtask

    task automatic receive_frame(input bit stall);
        int idx = 0;
        int guard = 0;
        bit stalled = 0;
        longint pr = 0, pi = 0, pl = 0;
        while (idx < N && guard < 3000) begin
            if (bus.out_valid) begin
                if (stalled) begin
                    check("stall_real", longint'(bus.out_real), pr);
                    check("stall_imag", longint'(bus.out_imag), pi);
                    check("stall_last", longint'(bus.out_last), pl);
                end
                bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (bus.out_ready) begin
                    check($sformatf("bin%0d_re", idx), longint'(bus.out_real), exp_re[idx]);
                    check($sformatf("bin%0d_im", idx), longint'(bus.out_imag), exp_im[idx]);
                    check($sformatf("bin%0d_last", idx), longint'(bus.out_last),
                          longint'(idx == N - 1));
                    idx++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pr = bus.out_real;
                    pi = bus.out_imag;
                    pl = longint'(bus.out_last);
                end
            end
            guard++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("unload_count", idx, N);
        check("post_out_valid", longint'(bus.out_valid), 0);
        check("post_in_ready", longint'(bus.in_ready), 1);
    endtask

    task automatic set_impulse();
        for (int i = 0; i < N; i++) begin
            xin[i] = (i == 0) ? IMP_AMP : 0;
            exp_re[i] = IMP_BIN;
            exp_im[i] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < N / 2; k++) begin
            wr[k] = rnd(1000.0 * $cos(2.0 * 3.14159265358979 * real'(k) / real'(N)));
            wi[k] = -rnd(1000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / real'(N)));
            tw_re_bus[k*TW +: TW] = TW'(wr[k]);
            tw_im_bus[k*TW +: TW] = TW'(wi[k]);
        end
        bus.in_valid  = 1'b0;
        bus.in_real   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_last", longint'(bus.out_last), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_out_real", longint'(bus.out_real), 0);
        check("rst_out_imag", longint'(bus.out_imag), 0);
        rst_n = 1'b1;

        set_impulse();
        send_frame();
        wait_compute();
        receive_frame(1'b0);

        for (int i = 0; i < N; i++) begin
            xin[i] = DC_AMP;
            exp_re[i] = (i == 0) ? DC_BIN0 : 0;
            exp_im[i] = 0;
        end
        send_frame();
        wait_compute();
        receive_frame(1'b0);

        for (int i = 0; i < N; i++) begin
            xin[i] = (i % 2 == 0) ? 100 : -100;
            exp_re[i] = (i == 16) ? ALT_BIN16 : 0;
            exp_im[i] = 0;
        end
        send_frame();
        wait_compute();
        receive_frame(1'b0);

        for (int i = 0; i < N; i++) xin[i] = longint'($urandom_range(0, 60000)) - 30000;
        build_ref();
        send_frame();
        wait_compute();
        receive_frame(1'b1);

        for (int i = 0; i < N; i++) begin
            int v;
            v = int'($urandom());
            xin[i] = v;
        end
        build_ref();
        send_frame();
        wait_compute();
        receive_frame(1'b1);

        for (int i = 0; i < N; i++) xin[i] = longint'($urandom_range(0, 2000)) - 1000;
        send_frame();
        repeat (20) @(negedge clk);
        check("pre_abort_busy", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", longint'(bus.in_ready), 1);
        check("abort_out_valid", longint'(bus.out_valid), 0);
        check("abort_busy", longint'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_impulse();
        send_frame();
        wait_compute();
        receive_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
